// File: rtl/lorenz_pkg.sv
// Shared constants and types for the Lorenz-attractor keystream block.
// Holds the attractor state widths, the byte width, the FSM state encoding
// and the default warm-up length and FIFO depth.
package lorenz_pkg;

  localparam int X_W                = 33;
  localparam int YZ_W               = 34;
  localparam int BYTE_W             = 8;
  localparam int WARMUP_DEFAULT     = 16;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } ks_state_t;

endpackage

// File: rtl/ks_fifo.sv
// Small synchronous FIFO used as the keystream byte buffer.
// Latency: a byte pushed into an empty FIFO appears on head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored; the caller
//   uses full/empty to avoid them.
// Ports: clk, rst (sync, active-high), push/push_data, pop, full, empty,
//   head (value of the oldest entry, driven straight from storage registers).
module ks_fifo
  import lorenz_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int W     = BYTE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared so the head reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lorenz_keystream.sv
// Keystream generator: XORs one bit of each Lorenz state variable per accepted
//   sample, discards WARMUP samples after each enable rise, packs bits MSB-first
//   into bytes and buffers them in a small FIFO.
// Latency: a completed byte is visible on out_data one cycle after its last bit
//   is accepted (when the FIFO was empty).
// Backpressure: in_ready drops only while a byte is about to complete and the
//   FIFO is full; it depends on registered state only.
// Ports: clk, rst (sync, active-high), enable, in_valid/in_ready with x_in,
//   y_in, z_in samples, out_valid/out_ready with out_data bytes.
// Optional: define KS_VON_NEUMANN_EN to debias raw bits in pairs before packing.
module lorenz_keystream
  import lorenz_pkg::*;
#(
  parameter int WARMUP     = WARMUP_DEFAULT,
  parameter int BIT_SEL    = 0,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    x_in,
  input  logic [YZ_W-1:0]   y_in,
  input  logic [YZ_W-1:0]   z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data
);

  localparam int WCW = $clog2(WARMUP + 2);

  ks_state_t         state_q, state_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d, wcnt_inc;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [BYTE_W-1:0] sreg_q, sreg_d;
  logic              accept;
  logic              raw_bit;
  logic              bit_take;
  logic              bit_val;
  logic              push;
  logic [BYTE_W-1:0] push_byte;
  logic              fifo_full;
  logic              fifo_empty;
  logic              byte_pending;
  // Only bit BIT_SEL of each state variable is used; the rest are folded here
  // so the remaining input bits are deliberately consumed.
  logic              unused_state_bits;

`ifdef KS_VON_NEUMANN_EN
  logic phase_q, phase_d;
  logic first_q, first_d;
  assign byte_pending = phase_q && (bcnt_q == 3'd7);
`else
  assign byte_pending = (bcnt_q == 3'd7);
`endif

  assign unused_state_bits = ^{x_in, y_in, z_in};
  assign raw_bit   = x_in[BIT_SEL] ^ y_in[BIT_SEL] ^ z_in[BIT_SEL];
  assign in_ready  = !((state_q == ST_RUN) && byte_pending && fifo_full);
  assign accept    = in_valid && in_ready;
  assign wcnt_inc  = wcnt_q + WCW'(1);
  assign out_valid = !fifo_empty;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    sreg_d    = sreg_q;
    push      = 1'b0;
    push_byte = {sreg_q[BYTE_W-2:0], bit_val};
    bit_take  = 1'b0;
    bit_val   = 1'b0;
`ifdef KS_VON_NEUMANN_EN
    phase_d   = phase_q;
    first_d   = first_q;
`endif
    case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        bcnt_d = '0;
        sreg_d = '0;
        if (enable) begin
          state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (accept) begin
          if (wcnt_inc == WCW'(WARMUP)) begin
            state_d = ST_RUN;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
`ifdef KS_VON_NEUMANN_EN
          // First bit of a pair is parked; unequal pairs emit the first bit.
          if (!phase_q) begin
            phase_d = 1'b1;
            first_d = raw_bit;
          end else begin
            phase_d = 1'b0;
            if (first_q != raw_bit) begin
              bit_take = 1'b1;
              bit_val  = first_q;
            end
          end
`else
          bit_take = 1'b1;
          bit_val  = raw_bit;
`endif
        end
        if (bit_take) begin
          sreg_d    = {sreg_q[BYTE_W-2:0], bit_val};
          push_byte = {sreg_q[BYTE_W-2:0], bit_val};
          bcnt_d    = bcnt_q + 3'd1;
          push      = (bcnt_q == 3'd7);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping enable abandons any partial byte and pending pair.
    if (!enable) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
      bcnt_d  = '0;
      sreg_d  = '0;
      push    = 1'b0;
`ifdef KS_VON_NEUMANN_EN
      phase_d = 1'b0;
      first_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
`ifdef KS_VON_NEUMANN_EN
      phase_q <= 1'b0;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
`ifdef KS_VON_NEUMANN_EN
      phase_q <= phase_d;
      first_q <= first_d;
`endif
    end
  end

  ks_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_byte),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

endmodule

// File: tb/tb_lorenz_keystream.sv
// Directed bench for lorenz_keystream with default parameters.
// Drives and samples 1 time unit after each rising clock edge.
module tb_lorenz_keystream;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] x_in;
  logic [33:0] y_in;
  logic [33:0] z_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lorenz_keystream dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random upper bits and random y/z bit 0; x bit 0 is chosen so the XOR is b.
  task automatic send(input logic b);
    int   g;
    logic y0;
    logic z0;
    g  = 0;
    y0 = 1'($urandom_range(0, 1));
    z0 = 1'($urandom_range(0, 1));
    x_in = {32'($urandom), b ^ y0 ^ z0};
    y_in = {33'({$urandom, $urandom}), y0};
    z_in = {33'({$urandom, $urandom}), z0};
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, g);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send(v[i]);
    end
  endtask

  task automatic warmup_samples();
    for (int i = 0; i < 16; i++) begin
      send(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic pop_byte(output logic [7:0] d, output logic ok);
    int g;
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    ok = out_valid;
    d  = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    idle(2);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h, expected 00", out_data);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_ones_byte();
    logic [7:0] d;
    logic       ok;
    warmup_samples();
    for (int i = 0; i < 7; i++) begin
      send(1'b1);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_byte: out_valid=%b after 23 samples, expected 0", out_valid);
    end
    send(1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL ones_byte: valid=%b data=%h, expected 1/ff", out_valid, out_data);
    end
    pop_byte(d, ok);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_single: out_valid=%b after one pop, expected 0", out_valid);
    end
  endtask

  task automatic test_pattern();
    logic [7:0] d;
    logic       ok;
    send_byte(8'hAA);
    send_byte(8'h81);
    pop_byte(d, ok);
    n_cmp++;
    if (!ok || d !== 8'hAA) begin
      n_fail++;
      $display("FAIL pattern_aa: valid=%b data=%h, expected 1/aa", ok, d);
    end
    pop_byte(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h81) begin
      n_fail++;
      $display("FAIL pattern_81: valid=%b data=%h, expected 1/81", ok, d);
    end
  endtask

  task automatic test_full();
    logic [7:0] d;
    logic       ok;
    logic [7:0] exp_q [4];
    logic [7:0] last;
    exp_q = '{8'h34, 8'h56, 8'h78, 8'h9A};
    last  = 8'h9A;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    for (int i = 7; i >= 1; i--) begin
      send(last[i]);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_stall: in_ready=%b, expected 0", in_ready);
    end
    idle(2);
    n_cmp++;
    if (in_ready !== 1'b0 || out_data !== 8'h12) begin
      n_fail++;
      $display("FAIL full_hold: in_ready=%b head=%h, expected 0/12", in_ready, out_data);
    end
    pop_byte(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h12 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_release: data=%h in_ready=%b, expected 12/1", d, in_ready);
    end
    send(last[0]);
    for (int i = 0; i < 4; i++) begin
      pop_byte(d, ok);
      n_cmp++;
      if (!ok || d !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_order%0d: valid=%b data=%h, expected 1/%h", i, ok, d, exp_q[i]);
      end
    end
  endtask

  task automatic test_reenable();
    logic [7:0] d;
    logic       ok;
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
    end
    enable = 1'b0;
    idle(1);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL disable_keep: in_ready=%b valid=%b data=%h, expected 1/1/c3",
               in_ready, out_valid, out_data);
    end
    enable = 1'b1;
    idle(1);
    warmup_samples();
    for (int i = 0; i < 7; i++) begin
      send(1'b0);
    end
    n_cmp++;
    if (out_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL reenable_warmup: head=%h, expected c3", out_data);
    end
    send(1'b1);
    pop_byte(d, ok);
    n_cmp++;
    if (!ok || d !== 8'hC3) begin
      n_fail++;
      $display("FAIL reenable_old: valid=%b data=%h, expected 1/c3", ok, d);
    end
    pop_byte(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h01) begin
      n_fail++;
      $display("FAIL reenable_fresh: valid=%b data=%h, expected 1/01", ok, d);
    end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] d;
    logic       ok;
    send_byte(8'h3C);
    send(1'b1);
    send(1'b1);
    send(1'b1);
    rst = 1'b1;
    idle(1);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b data=%h in_ready=%b, expected 0/00/1",
               out_valid, out_data, in_ready);
    end
    rst = 1'b0;
    idle(1);
    warmup_samples();
    send_byte(8'h5A);
    pop_byte(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: valid=%b data=%h, expected 1/5a", ok, d);
    end
  endtask

`ifdef KS_VON_NEUMANN_EN
  task automatic test_von_neumann();
    logic [7:0] d;
    logic       ok;
    logic [7:0] raw;
    raw = 8'b0110_1100;
    warmup_samples();
    for (int r = 0; r < 4; r++) begin
      for (int i = 7; i >= 0; i--) begin
        send(raw[i]);
      end
    end
    pop_byte(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h55) begin
      n_fail++;
      $display("FAIL von_neumann: valid=%b data=%h, expected 1/55", ok, d);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    #1;
    test_reset();
`ifdef KS_VON_NEUMANN_EN
    test_von_neumann();
`else
    test_ones_byte();
    test_pattern();
    test_full();
    test_reenable();
    test_reset_midbyte();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lorenz_keystream.md
LORENZ_KEYSTREAM -- requirements
Module: lorenz_keystream

Interface
REQ-001 Parameter WARMUP, default 16: number of accepted samples discarded after each enable rise.
REQ-002 Parameter BIT_SEL, default 0: bit index taken from each state variable.
REQ-003 Parameter FIFO_DEPTH, default 4: output byte FIFO depth, power of two.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  run request; low forces IDLE.
REQ-007 in_valid  input  1  attractor sample valid.
REQ-008 in_ready  output  1  sample accepted when in_valid&&in_ready.
REQ-009 x_in  input  33  attractor x state, fixed-point.
REQ-010 y_in  input  34  attractor y state.
REQ-011 z_in  input  34  attractor z state.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer pops head byte when out_valid&&out_ready.
REQ-014 out_data  output  8  FIFO head byte.

Function
REQ-015 States: IDLE, WARMUP, RUN; enable low in any state -> IDLE next cycle.
REQ-016 IDLE: in_ready=1, samples dropped, warm-up counter and bit counter held at 0; enable high -> WARMUP.
REQ-017 WARMUP: each accepted sample increments warm-up counter; the WARMUP-th accepted sample moves to RUN, producing no bit; WARMUP=0 goes IDLE->RUN directly.
REQ-018 RUN: each accepted sample yields raw bit b = x_in[BIT_SEL]^y_in[BIT_SEL]^z_in[BIT_SEL].
REQ-019 Bits pack MSB-first: first bit of a byte lands in bit 7; 3-bit counter wraps 7->0.
REQ-020 Completing bit (counter 7) pushes the full byte into FIFO in the same edge; pushed byte visible on out_data (if FIFO was empty) next cycle.
REQ-021 in_ready = 0 only when state RUN, counter==7 (or debias pair completing with a byte pending), and FIFO full; computed from registered state only, no out_ready feed-through.
REQ-022 Simultaneous push and pop with FIFO full: illegal by REQ-021; with FIFO non-full: both occur, occupancy unchanged.
REQ-023 Leaving RUN (enable low) discards the partial byte; FIFO contents preserved and still drainable; re-enable repeats full warm-up.
REQ-024 out_data holds value while out_valid&&!out_ready.

Reset
REQ-025 rst: state IDLE, counters 0, shift register 0, FIFO empty, out_valid=0, out_data=8'h00, in_ready=1.
REQ-026 rst overrides enable and all handshakes in the same cycle; mid-byte and mid-warm-up progress lost.

Configuration
REQ-027 Macro KS_VON_NEUMANN_EN defined: RUN raw bits taken in pairs; (0,1)->0, (1,0)->1, (0,0)/(1,1) discarded; first bit of pair held in 1-bit register with pair-phase flag, cleared on leaving RUN.
REQ-028 Macro undefined: every raw bit packed directly; no pair logic present.

Structure
REQ-029 Package lorenz_pkg: state-width constants (X_W=33, YZ_W=34), byte width, state enum typedef, default WARMUP/FIFO_DEPTH.
REQ-030 One sub-module ks_fifo: synchronous FIFO, 8-bit, FIFO_DEPTH entries, full/empty flags, head output registered-read.

Verification
REQ-031 rst high 2 cycles, enable=1 -> out_valid=0, out_data=8'h00, in_ready=1, no byte until 16+8 samples accepted.
REQ-032 enable=1, 16 warm-up samples then 8 samples each with x_in[0]=1,y_in[0]=0,z_in[0]=0 -> exactly one byte 8'hFF.
REQ-033 RUN raw bits 1,0,1,0,1,0,1,0 -> 8'hAA; then 1,0,0,0,0,0,0,1 -> 8'h81, in that order.
REQ-034 out_ready=0, feed 32 bits then 7 more -> FIFO full, in_ready=0 at counter 7; one pop -> in_ready=1 next cycle, 8'hAA-style head order preserved.
REQ-035 enable low after 5 RUN bits, high again -> partial discarded, 16 samples re-discarded, next byte built from fresh bits, earlier FIFO bytes drain unchanged.
REQ-036 KS_VON_NEUMANN_EN: raw pairs (0,1),(1,0),(1,1),(0,0) repeated -> packed bits 0,1 only; 8 kept bits 0,1,0,1,0,1,0,1 -> 8'h55.
